cpwm_shadow_commit_ctrl: RTL and testbench
==========================================

// Module: cpwm_shadow_commit_ctrl
// PURPOSE
// Double-buffers per-channel period/compare values for the 8-carrier PWM core and commits them to the active
// registers only on each channel's own carrier event, so duty/period updates never produce glitched pulses.
// Sits between the AXI4-Lite register bank and the carrier/compare datapath; drives its period_x/compare_x buses.
// A global commit request arms the selected loaded channels, and a timeout forces the commit if a carrier is stopped.
// PARAMETERS
// N_CH   8   number of PWM channels (= PWM_WIDTH)
// CNT_W  16  period/compare width (= PWMCOUNT_WIDTH)
// TO_W   24  timeout counter width
// PORTS
// clk             in   1          system clock
// reset           in   1          synchronous, active-high reset
// wr_en           in   1          shadow write strobe (one cycle)
// wr_ch           in   3          target channel of shadow write
// wr_period       in   CNT_W      new period value
// wr_compare      in   CNT_W      new compare value
// commit_req      in   1          arm all LOADED channels selected by commit_mask (pulse)
// commit_mask     in   N_CH       channel select for commit_req
// sync_event      in   N_CH       per-carrier event pulses (masked events from carrier generators)
// timeout_cycles  in   TO_W       forced-commit timeout; 0 = disabled
// flag_clr        in   1          clears timeout_flag and wr_err
// period_x        out  N_CH*CNT_W active periods, channel i at [CNT_W*(i+1)-1:CNT_W*i]
// compare_x       out  N_CH*CNT_W active compares, same packing
// loaded          out  N_CH       shadow holds unarmed new data
// armed           out  N_CH       channel waiting for its sync_event
// commit_pulse    out  N_CH       one-cycle pulse when channel i's active regs update
// busy            out  1          OR of armed
// timeout_flag    out  1          sticky: a forced commit occurred
// wr_err          out  1          sticky: write to an ARMED channel rejected
// BEHAVIOUR
// - Reset: period_x=0, compare_x=0, shadows=0, all channels EMPTY, loaded/armed/commit_pulse=0, busy=0,
//   timeout_flag=0, wr_err=0, timeout counter=0. Reset mid-operation discards all pending/armed data.
// - Per-channel FSM: EMPTY -wr_en-> LOADED; LOADED -wr_en-> LOADED (shadow overwritten);
//   LOADED -commit_req & mask[i]-> ARMED; ARMED -sync_event[i] or timeout-> EMPTY with commit.
// - commit_req with mask[i]=1 on an EMPTY channel: no effect. On ARMED: stays ARMED.
// - wr_en to ARMED channel: write ignored, wr_err set; shadow unchanged.
// - wr_en and commit_req same cycle, same channel (EMPTY or LOADED): write lands, channel becomes ARMED with new data.
// - Arming is registered: sync_event[i] in the same cycle commit_req arms i is ignored; commit on next event.
// - Commit latency: sync_event[i] high in cycle t while ARMED -> period/compare for i updated and commit_pulse[i]=1
//   in t+1; period and compare of one channel always update in the same cycle.
// - Multiple channels may commit in the same cycle; each independent.
// - Timeout counter: cleared to 0 on any commit_req that arms >=1 channel; increments while busy; held at 0 when
//   not busy. When timeout_cycles!=0 and counter==timeout_cycles-1, every still-ARMED channel commits next
//   cycle (commit_pulse asserted), timeout_flag set. Counter saturates, no wrap.
// - flag_clr same cycle as a new set event: set wins.
// - loaded/armed/busy are registered state, valid one cycle after the causing strobe.
// TESTING
// - Reset; write ch2 (P=1000,C=400); commit_req mask=0x04; sync_event[2] at t -> period ch2=1000, compare=400,
//   commit_pulse[2] at t+1; armed=0.
// - Write ch0, ch5; commit mask=0x21; pulse sync_event[0] and [5] same cycle -> both commit in same cycle.
// - Arm ch1; sync_event[1] in arming cycle -> no commit; next sync_event[1] -> commit.
// - Arm ch3; write ch3 while ARMED -> wr_err=1, committed value is original shadow; flag_clr -> wr_err=0.
// - timeout_cycles=10, arm ch7, no events -> forced commit 10 cycles after arming, timeout_flag=1.
// - Arm ch4, assert reset before event -> outputs 0, armed=0, no commit_pulse after reset.

Source files
------------

// File: rtl/cpwm_shadow_commit_ctrl.sv
// Shadow/active double buffer for the PWM period and compare registers.
// Each channel has its own small FSM with three states: EMPTY, LOADED and ARMED.
// New values stay in a shadow register until the channel's own carrier event arrives.
// On that event the shadow values are copied to the active registers.
// A timeout forces the copy for any channel whose carrier has stopped.
//
// Handshake: all strobes are single-cycle, level-sampled on the rising clock edge.
// No back-pressure exists. Instead, a write that targets an ARMED channel is dropped
// and reported through the sticky wr_err flag.
module cpwm_shadow_commit_ctrl #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16,
    parameter int TO_W  = 24,
    parameter int CH_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [CNT_W-1:0]      wr_period,
    input  logic [CNT_W-1:0]      wr_compare,
    input  logic                  commit_req,
    input  logic [N_CH-1:0]       commit_mask,
    input  logic [N_CH-1:0]       sync_event,
    input  logic [TO_W-1:0]       timeout_cycles,
    input  logic                  flag_clr,
    output logic [N_CH*CNT_W-1:0] period_x,
    output logic [N_CH*CNT_W-1:0] compare_x,
    output logic [N_CH-1:0]       loaded,
    output logic [N_CH-1:0]       armed,
    output logic [N_CH-1:0]       commit_pulse,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic                  wr_err,
    output logic [2*N_CH-1:0]     dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_ARMED  = 2'd2
    } ch_state_t;

    ch_state_t          r_state   [N_CH];
    ch_state_t          w_next    [N_CH];
    logic [CNT_W-1:0]   r_shd_per [N_CH];
    logic [CNT_W-1:0]   r_shd_cmp [N_CH];
    logic [CNT_W-1:0]   r_act_per [N_CH];
    logic [CNT_W-1:0]   r_act_cmp [N_CH];
    logic [N_CH-1:0]    r_pulse;
    logic [TO_W-1:0]    r_cnt;
    logic               r_timeout_flag;
    logic               r_wr_err;

    logic [N_CH-1:0]    w_wr_hit;
    logic [N_CH-1:0]    w_shadow_we;
    logic [N_CH-1:0]    w_fire;
    logic [N_CH-1:0]    w_loaded;
    logic [N_CH-1:0]    w_armed;
    logic               w_busy;
    logic               w_timeout;
    logic               w_arms_any;
    logic               w_wr_reject;

    // Decode the current channel states into flag vectors.
    always_comb begin
        w_loaded = '0;
        w_armed  = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_loaded[i] = (r_state[i] == ST_LOADED);
            w_armed[i]  = (r_state[i] == ST_ARMED);
        end
    end

    assign w_busy = |w_armed;

    // The timeout fires once the counter reaches timeout_cycles-1 while any channel is armed.
    // A timeout_cycles value of 0 disables the timeout.
    assign w_timeout = (timeout_cycles != '0) && w_busy &&
                       (r_cnt == (timeout_cycles - TO_W'(1)));

    // Per-channel next-state logic and the write, arm and commit qualifiers.
    always_comb begin
        w_wr_hit    = '0;
        w_shadow_we = '0;
        w_fire      = '0;
        w_arms_any  = 1'b0;
        w_wr_reject = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            w_next[i]      = r_state[i];
            w_wr_hit[i]    = wr_en && (int'(wr_ch) == i);
            w_shadow_we[i] = w_wr_hit[i] && (r_state[i] != ST_ARMED);
            case (r_state[i])
                ST_EMPTY: begin
                    if (w_wr_hit[i]) begin
                        if (commit_req && commit_mask[i]) begin
                            w_next[i]  = ST_ARMED;
                            w_arms_any = 1'b1;
                        end else begin
                            w_next[i] = ST_LOADED;
                        end
                    end
                end
                ST_LOADED: begin
                    if (commit_req && commit_mask[i]) begin
                        w_next[i]  = ST_ARMED;
                        w_arms_any = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_wr_hit[i]) begin
                        w_wr_reject = 1'b1;
                    end
                    if (sync_event[i] || w_timeout) begin
                        w_fire[i] = 1'b1;
                        w_next[i] = ST_EMPTY;
                    end
                end
                default: w_next[i] = ST_EMPTY;
            endcase
        end
    end

    // Register the channel states, the shadow and active values, and the commit pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i]   <= ST_EMPTY;
                r_shd_per[i] <= '0;
                r_shd_cmp[i] <= '0;
                r_act_per[i] <= '0;
                r_act_cmp[i] <= '0;
            end
        end else begin
            r_pulse <= w_fire;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_next[i];
                if (w_shadow_we[i]) begin
                    r_shd_per[i] <= wr_period;
                    r_shd_cmp[i] <= wr_compare;
                end
                if (w_fire[i]) begin
                    r_act_per[i] <= r_shd_per[i];
                    r_act_cmp[i] <= r_shd_cmp[i];
                end
            end
        end
    end

    // Timeout counter: restarts on every successful arm, counts while busy, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_arms_any) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky flags. When a set and a clear arrive in the same cycle, the set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_flag <= 1'b0;
            r_wr_err       <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (flag_clr) begin
                r_timeout_flag <= 1'b0;
            end
            if (w_wr_reject) begin
                r_wr_err <= 1'b1;
            end else if (flag_clr) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_pack
            assign period_x[CNT_W*g +: CNT_W]  = r_act_per[g];
            assign compare_x[CNT_W*g +: CNT_W] = r_act_cmp[g];
            assign dbg_state[2*g +: 2]         = r_state[g];
        end
    endgenerate

    assign loaded       = w_loaded;
    assign armed        = w_armed;
    assign busy         = w_busy;
    assign commit_pulse = r_pulse;
    assign timeout_flag = r_timeout_flag;
    assign wr_err       = r_wr_err;

endmodule

// File: tb/tb_cpwm_shadow_commit_ctrl.sv
// Directed bench for cpwm_shadow_commit_ctrl with hand-computed expected values.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
module tb_cpwm_shadow_commit_ctrl;

    localparam int N_CH  = 8;
    localparam int CNT_W = 16;
    localparam int TO_W  = 24;
    localparam int CH_W  = 3;

    logic                  clk;
    logic                  reset;
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic [CNT_W-1:0]      wr_period;
    logic [CNT_W-1:0]      wr_compare;
    logic                  commit_req;
    logic [N_CH-1:0]       commit_mask;
    logic [N_CH-1:0]       sync_event;
    logic [TO_W-1:0]       timeout_cycles;
    logic                  flag_clr;
    logic [N_CH*CNT_W-1:0] period_x;
    logic [N_CH*CNT_W-1:0] compare_x;
    logic [N_CH-1:0]       loaded;
    logic [N_CH-1:0]       armed;
    logic [N_CH-1:0]       commit_pulse;
    logic                  busy;
    logic                  timeout_flag;
    logic                  wr_err;
    logic [2*N_CH-1:0]     dbg_state;

    int n_checks;
    int n_fail;

    // Expected active values per channel
    logic [CNT_W-1:0] exp_per [N_CH];
    logic [CNT_W-1:0] exp_cmp [N_CH];

    cpwm_shadow_commit_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TO_W(TO_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_period(wr_period), .wr_compare(wr_compare),
        .commit_req(commit_req), .commit_mask(commit_mask),
        .sync_event(sync_event), .timeout_cycles(timeout_cycles),
        .flag_clr(flag_clr), .period_x(period_x), .compare_x(compare_x),
        .loaded(loaded), .armed(armed), .commit_pulse(commit_pulse),
        .busy(busy), .timeout_flag(timeout_flag), .wr_err(wr_err),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH*CNT_W-1:0] pack_per();
        logic [N_CH*CNT_W-1:0] v;
        for (int i = 0; i < N_CH; i++) v[CNT_W*i +: CNT_W] = exp_per[i];
        return v;
    endfunction

    function automatic logic [N_CH*CNT_W-1:0] pack_cmp();
        logic [N_CH*CNT_W-1:0] v;
        for (int i = 0; i < N_CH; i++) v[CNT_W*i +: CNT_W] = exp_cmp[i];
        return v;
    endfunction

    task automatic do_write(input int ch, input int p, input int c);
        wr_en      = 1'b1;
        wr_ch      = CH_W'(ch);
        wr_period  = CNT_W'(p);
        wr_compare = CNT_W'(c);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input logic [N_CH-1:0] m);
        commit_req  = 1'b1;
        commit_mask = m;
        tick();
        commit_req  = 1'b0;
        commit_mask = '0;
    endtask

    task automatic do_sync(input logic [N_CH-1:0] m);
        sync_event = m;
        tick();
        sync_event = '0;
    endtask

    task automatic check_active(input string tag);
        check_val({tag, "_period"}, period_x, pack_per());
        check_val({tag, "_compare"}, compare_x, pack_cmp());
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < N_CH; i++) begin
            exp_per[i] = '0;
            exp_cmp[i] = '0;
        end
        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_compare = '0;
        commit_req = 1'b0; commit_mask = '0; sync_event = '0;
        timeout_cycles = '0; flag_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_active("rst");
        check_val("rst_loaded", loaded, 0);
        check_val("rst_armed", armed, 0);
        check_val("rst_pulse", commit_pulse, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_tflag", timeout_flag, 0);
        check_val("rst_wrerr", wr_err, 0);
        check_val("rst_dbg", dbg_state, 0);

        // Basic commit on channel 2
        do_write(2, 1000, 400);
        check_val("t1_loaded", loaded, 8'h04);
        do_commit(8'h04);
        check_val("t1_armed", armed, 8'h04);
        check_val("t1_loaded_clr", loaded, 0);
        check_val("t1_busy", busy, 1);
        check_active("t1_hold");
        do_sync(8'h04);
        exp_per[2] = 16'd1000; exp_cmp[2] = 16'd400;
        check_val("t1_pulse", commit_pulse, 8'h04);
        check_active("t1_commit");
        check_val("t1_armed_clr", armed, 0);
        tick();
        check_val("t1_pulse_end", commit_pulse, 0);

        // Two channels commit in the same cycle
        do_write(0, 200, 50);
        do_write(5, 3000, 1500);
        check_val("t2_loaded", loaded, 8'h21);
        do_commit(8'h21);
        check_val("t2_armed", armed, 8'h21);
        do_sync(8'h21);
        exp_per[0] = 16'd200;  exp_cmp[0] = 16'd50;
        exp_per[5] = 16'd3000; exp_cmp[5] = 16'd1500;
        check_val("t2_pulse", commit_pulse, 8'h21);
        check_active("t2_commit");

        // A sync event in the same cycle as arming is ignored
        do_write(1, 77, 33);
        commit_req = 1'b1; commit_mask = 8'h02; sync_event = 8'h02;
        tick();
        commit_req = 1'b0; commit_mask = '0; sync_event = '0;
        check_val("t3_no_pulse", commit_pulse, 0);
        check_val("t3_armed", armed, 8'h02);
        check_active("t3_hold");
        do_sync(8'h02);
        exp_per[1] = 16'd77; exp_cmp[1] = 16'd33;
        check_val("t3_pulse", commit_pulse, 8'h02);
        check_active("t3_commit");

        // A commit request on an EMPTY channel has no effect
        do_commit(8'h40);
        check_val("t3b_empty_armed", armed, 0);
        check_val("t3b_empty_busy", busy, 0);

        // A write and a commit in the same cycle land and arm together
        wr_en = 1'b1; wr_ch = 3'd6; wr_period = 16'd600; wr_compare = 16'd60;
        commit_req = 1'b1; commit_mask = 8'h40;
        tick();
        wr_en = 1'b0; commit_req = 1'b0; commit_mask = '0;
        check_val("t3c_armed", armed, 8'h40);
        check_val("t3c_loaded", loaded, 0);
        do_sync(8'h40);
        exp_per[6] = 16'd600; exp_cmp[6] = 16'd60;
        check_active("t3c_commit");

        // A write to an ARMED channel is rejected
        do_write(3, 500, 250);
        do_commit(8'h08);
        do_write(3, 999, 111);
        check_val("t4_wrerr", wr_err, 1);
        check_val("t4_armed", armed, 8'h08);
        // A new reject in the same cycle as flag_clr keeps wr_err set
        flag_clr = 1'b1;
        do_write(3, 888, 222);
        flag_clr = 1'b0;
        check_val("t4_set_wins", wr_err, 1);
        do_sync(8'h08);
        exp_per[3] = 16'd500; exp_cmp[3] = 16'd250;
        check_val("t4_pulse", commit_pulse, 8'h08);
        check_active("t4_commit");
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check_val("t4_wrerr_clr", wr_err, 0);

        // A timeout forces the commit 10 cycles after arming
        timeout_cycles = 24'd10;
        do_write(7, 1234, 567);
        do_commit(8'h80);
        for (int k = 0; k < 9; k++) begin
            check_val("t5_no_early_pulse", commit_pulse, 0);
            tick();
        end
        check_val("t5_still_armed", armed, 8'h80);
        check_val("t5_no_flag_yet", timeout_flag, 0);
        tick();
        exp_per[7] = 16'd1234; exp_cmp[7] = 16'd567;
        check_val("t5_pulse", commit_pulse, 8'h80);
        check_val("t5_tflag", timeout_flag, 1);
        check_val("t5_armed_clr", armed, 0);
        check_active("t5_commit");
        timeout_cycles = '0;
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check_val("t5_tflag_clr", timeout_flag, 0);

        // A reset while a channel is armed discards the pending data
        do_write(4, 42, 21);
        do_commit(8'h10);
        check_val("t6_armed", armed, 8'h10);
        check_val("t6_dbg", dbg_state, 16'h0200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            exp_per[i] = '0;
            exp_cmp[i] = '0;
        end
        check_active("t6_rst");
        check_val("t6_armed_clr", armed, 0);
        check_val("t6_pulse", commit_pulse, 0);
        do_sync(8'h10);
        check_val("t6_no_pulse", commit_pulse, 0);
        check_active("t6_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
